systolic_feeder: RTL

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_skew_lane.sv | 27 ++
 rtl/systolic_feeder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder: default sizing, feeder state encoding
// and the lane-packing index helper.
package systolic_pkg;

  localparam int unsigned SizeDefault  = 4;
  localparam int unsigned IBitsDefault = 8;

  typedef enum logic [2:0] {
    StLoad,
    StFull,
    StClear,
    StRun,
    StDone
  } feeder_state_e;

  // LSB of lane q inside a packed lane bus of bits-wide elements.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned bits);
    return lane * bits;
  endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// One skewed lane: picks element (t - LANE) of its row/column, or zero outside the diagonal
// window or when disabled.
module systolic_skew_lane
  import systolic_pkg::*;
#(
  parameter int unsigned SIZE   = SizeDefault,
  parameter int unsigned I_BITS = IBitsDefault,
  parameter int unsigned T_BITS = 4,
  parameter int unsigned LANE   = 0
) (
  input  logic [T_BITS-1:0]      t_i,
  input  logic                   en_i,
  input  logic [SIZE*I_BITS-1:0] elems_i,
  output logic [I_BITS-1:0]      lane_o
);

  int idx;

  always_comb begin
    idx    = int'(t_i) - int'(LANE);
    lane_o = '0;
    if (en_i && idx >= 0 && idx < int'(SIZE)) begin
      lane_o = elems_i[idx*int'(I_BITS) +: I_BITS];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers one SIZE x SIZE pair of operand matrices, then streams them diagonally skewed
// into a systolic array after a one-cycle accumulator clear.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned SIZE   = SizeDefault,
  parameter int unsigned I_BITS = IBitsDefault
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [I_BITS-1:0]      i_data_a,
  input  logic [I_BITS-1:0]      i_data_b,
  input  logic                   i_start,
  output logic                   o_clear,
  output logic [I_BITS*SIZE-1:0] o_a_full,
  output logic [I_BITS*SIZE-1:0] o_b_full,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned NumElems = SIZE * SIZE;
  localparam int unsigned KBits    = (NumElems > 1) ? $clog2(NumElems) : 1;
  localparam int unsigned TBits    = $clog2(3 * SIZE);
  localparam logic [KBits-1:0] LastK = KBits'(NumElems - 1);
  localparam logic [TBits-1:0] LastT = TBits'(3 * SIZE - 3);

  feeder_state_e state_q, state_d;
  logic [KBits-1:0] k_q, k_d;
  logic [TBits-1:0] t_q, t_d;

  logic [I_BITS-1:0] a_mem [NumElems];
  logic [I_BITS-1:0] b_mem [NumElems];

  logic [SIZE*I_BITS-1:0] a_rows [SIZE];
  logic [SIZE*I_BITS-1:0] b_cols [SIZE];
  logic [SIZE*I_BITS-1:0] a_lanes_d, b_lanes_d, a_lanes_q, b_lanes_q;

  logic             beat;
  logic             lane_en;
  logic [TBits-1:0] lane_t;

  assign beat = i_valid && (state_q == StLoad);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    unique case (state_q)
      StLoad: begin
        if (i_valid) begin
          if (k_q == LastK) begin
            k_d     = '0;
            state_d = StFull;
          end else begin
            k_d = k_q + KBits'(1);
          end
        end
      end
      StFull: begin
        if (i_start) state_d = StClear;
      end
      StClear: begin
        state_d = StRun;
        t_d     = '0;
      end
      StRun: begin
        if (t_q == LastT) begin
          state_d = StDone;
          t_d     = '0;
        end else begin
          t_d = t_q + TBits'(1);
        end
      end
      StDone: state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= StLoad;
      k_q       <= '0;
      t_q       <= '0;
      a_lanes_q <= '0;
      b_lanes_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      t_q       <= t_d;
      a_lanes_q <= a_lanes_d;
      b_lanes_q <= b_lanes_d;
    end
  end

  // Operand storage is deliberately not reset; contents survive until overwritten.
  always_ff @(posedge i_clock) begin
    if (beat) begin
      a_mem[k_q] <= i_data_a;
      b_mem[k_q] <= i_data_b;
    end
  end

  // Lanes are computed for the cycle about to be entered so the registered output lines up
  // with the RUN state: t=0 while in CLEAR, t+1 while in RUN, nothing on the last RUN cycle.
  assign lane_en = (state_q == StClear) || ((state_q == StRun) && (t_q != LastT));
  assign lane_t  = (state_q == StClear) ? '0 : t_q + TBits'(1);

  for (genvar q = 0; q < SIZE; q++) begin : g_lane
    for (genvar c = 0; c < SIZE; c++) begin : g_pack
      assign a_rows[q][c*I_BITS +: I_BITS] = a_mem[q*SIZE + c];
      assign b_cols[q][c*I_BITS +: I_BITS] = b_mem[c*SIZE + q];
    end

    systolic_skew_lane #(
      .SIZE  (SIZE),
      .I_BITS(I_BITS),
      .T_BITS(TBits),
      .LANE  (q)
    ) u_a_lane (
      .t_i    (lane_t),
      .en_i   (lane_en),
      .elems_i(a_rows[q]),
      .lane_o (a_lanes_d[lane_lsb(q, I_BITS) +: I_BITS])
    );

    systolic_skew_lane #(
      .SIZE  (SIZE),
      .I_BITS(I_BITS),
      .T_BITS(TBits),
      .LANE  (q)
    ) u_b_lane (
      .t_i    (lane_t),
      .en_i   (lane_en),
      .elems_i(b_cols[q]),
      .lane_o (b_lanes_d[lane_lsb(q, I_BITS) +: I_BITS])
    );
  end

  assign o_ready  = (state_q == StLoad);
  assign o_clear  = (state_q == StClear);
  assign o_busy   = (state_q == StClear) || (state_q == StRun);
  assign o_done   = (state_q == StDone);
  assign o_a_full = a_lanes_q;
  assign o_b_full = b_lanes_q;

endmodule
